// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit: op encodings,
// FSM states, default latencies and the combinational result function.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Returns {hi, lo}. Divide-by-zero and INT_MIN/-1 are steered to fixed
  // results; the divisor is also substituted so the divider never sees them.
  function automatic logic [63:0] mdu_compute(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        bs;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [63:0]        res;

    div_zero = (b == 32'd0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    bs       = (div_zero || div_ovf) ? 32'd1 : b;

    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    sq    = $signed(a) / $signed(bs);
    sr    = $signed(a) % $signed(bs);
    uq    = a / bs;
    ur    = a % bs;

    res = 64'd0;
    case (op)
      MDU_MULT:  res = sprod;
      MDU_MULTU: res = uprod;
      MDU_DIV: begin
        if (div_zero)     res = {a, 32'hFFFF_FFFF};
        else if (div_ovf) res = {32'd0, 32'h8000_0000};
        else              res = {sr, sq};
      end
      MDU_DIVU: begin
        if (div_zero) res = {a, 32'hFFFF_FFFF};
        else          res = {ur, uq};
      end
      default:   res = 64'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Result is computed on the
// accepting edge, held in a pending register and committed after N busy cycles.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] result;

  assign result = mdu_compute(MDUop, A, B);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mdu_op_e'(MDUop))
            MDU_MULT, MDU_MULTU: begin
              {pend_hi_d, pend_lo_d} = result;
              cnt_d   = MULT_CNT;
              state_d = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              {pend_hi_d, pend_lo_d} = result;
              cnt_d   = DIV_CNT;
              state_d = ST_RUN;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Requests while running are dropped; the hazard unit stalls on busy.
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, arithmetic, boundary divides,
// MTHI/MTLO, ignored requests while busy, back-to-back and reset behaviour.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUop;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns how many sampled cycles busy was high (bounded).
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    MDUop = op; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; MDUop = 3'd0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; MDUop = 3'd0; A = 32'd0; B = 32'd0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int cyc;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_latency got=%0d exp=5", cyc); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
  endtask

  task automatic test_multu();
    int cyc;
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_latency got=%0d exp=5", cyc); end
    checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
    checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
  endtask

  task automatic test_div();
    int cyc;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_latency got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    issue(3'd4, 32'd100, 32'd7, cyc);
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=00000002", HI); end
  endtask

  task automatic test_div_zero();
    int cyc;
    issue(3'd4, 32'd7, 32'd0, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divu0_latency got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=ffffffff", LO); end
    checks++; if (HI !== 32'd7) begin errors++; $display("FAIL divu0_hi got=%h exp=00000007", HI); end
    issue(3'd3, 32'hFFFF_FFF0, 32'd0, cyc);
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got=%h exp=ffffffff", LO); end
    checks++; if (HI !== 32'hFFFF_FFF0) begin errors++; $display("FAIL div0_hi got=%h exp=fffffff0", HI); end
  endtask

  task automatic test_div_overflow();
    int cyc;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divovf_latency got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL divovf_hi got=%h exp=00000000", HI); end
  endtask

  task automatic test_mthi_mtlo();
    MDUop = 3'd5; A = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0; MDUop = 3'd0;
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got=%h exp=12345678", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy2 got=%b exp=0", busy); end
    MDUop = 3'd6; A = 32'h9ABC_DEF0; start = 1'b1;
    tick();
    start = 1'b0; MDUop = 3'd0;
    checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", LO); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", HI); end
  endtask

  task automatic test_none_ops();
    MDUop = 3'd0; A = 32'h5555_5555; B = 32'd1; start = 1'b1;
    tick();
    MDUop = 3'd7;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noneop_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL noneop_hi got=%h exp=12345678", HI); end
    checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL noneop_lo got=%h exp=9abcdef0", LO); end
  endtask

  task automatic test_run_ignore();
    int cyc;
    MDUop = 3'd1; A = 32'd2; B = 32'd3; start = 1'b1;
    tick();
    // MTLO, MTHI and DIV while busy must all be dropped.
    MDUop = 3'd6; A = 32'hAAAA_AAAA;
    tick();
    MDUop = 3'd5;
    tick();
    MDUop = 3'd3; A = 32'd9; B = 32'd2;
    tick();
    start = 1'b0; MDUop = 3'd0;
    cyc = 3;
    while (busy && cyc < 20) begin
      cyc++;
      tick();
    end
    checks++; if (cyc != 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", cyc); end
    checks++; if (LO !== 32'd6) begin errors++; $display("FAIL ignore_lo got=%h exp=00000006", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL ignore_hi got=%h exp=00000000", HI); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_nostart got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(3'd2, 32'd10, 32'd20, cyc);
    // First cycle with busy low: start the next op immediately.
    checks++; if (LO !== 32'd200) begin errors++; $display("FAIL b2b_first_lo got=%h exp=000000c8", LO); end
    issue(3'd4, 32'd50, 32'd8, cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_latency got=%0d exp=10", cyc); end
    checks++; if (LO !== 32'd6) begin errors++; $display("FAIL b2b_lo got=%h exp=00000006", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL b2b_hi got=%h exp=00000002", HI); end
  endtask

  task automatic test_reset_mid();
    MDUop = 3'd4; A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; MDUop = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", LO); end
    for (int i = 0; i < 12; i++) tick();
    checks++; if (LO !== 32'd0 || HI !== 32'd0) begin
      errors++; $display("FAIL rstmid_late got=%h_%h exp=0_0", HI, LO);
    end
    // Reset beats a simultaneous MTHI request.
    MDUop = 3'd5; A = 32'hFEED_FACE; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0; MDUop = 3'd0;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rst_vs_start_hi got=%h exp=0", HI); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_div_overflow();
    test_mthi_mtlo();
    test_none_ops();
    test_run_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
